// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing controller: load-use, branch flush, memory wait with timeout
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_dest,
  input  logic        ex_branch_taken,
  input  logic        ex_halt,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pipe_hold,
  output logic        halted,
  output logic        mem_error,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        mem_error_q, mem_error_d;
  logic        load_use;
  logic        mem_stall;

  // r0 is hardwired zero, so a load targeting it never blocks the ID instruction
  assign load_use = ex_mem_read && (ex_dest != 3'd0) &&
                    ((id_uses_rs && (id_rs == ex_dest)) ||
                     (id_uses_rt && (id_rt == ex_dest)));

  // HALT ignores the memory port; RUN and MEM_WAIT both honour a pending access
  assign mem_stall = (state_q != HALT) && mem_access && !mem_ready;

  // Combinational pipeline controls in priority order; reset forces every stage to take a NOP
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == HALT || mem_stall) begin
      // EX stays frozen, so a branch or load-use in flight is re-presented after the hold
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed anyway, so a coincident load-use is moot
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Next state, wait timer and sticky timeout flag
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 16'd0;
        end else if (ex_halt) begin
          state_d = HALT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == 16'(MEM_TIMEOUT - 1)) begin
          state_d     = HALT;
          wait_cnt_d  = 16'd0;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Saturating count of cycles in which the PC did not advance, frozen once halted
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (state_q != HALT && !pc_write && stall_cycles_q != 16'hFFFF) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= 16'd0;
      stall_cycles_q <= 16'd0;
      mem_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_error_q    <= mem_error_d;
    end
  end

  assign halted       = (state_q == HALT);
  assign mem_error    = mem_error_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  id_rs, id_rt, ex_dest;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, ex_halt;
  logic        mem_access, mem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
  logic        halted, mem_error;
  logic [15:0] stall_cycles;
  logic [4:0]  ctl;
  int          checks;
  int          errors;
  int          exp_stall;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
  localparam logic [4:0] C_NORM  = 5'b11000;
  localparam logic [4:0] C_LU    = 5'b00010;
  localparam logic [4:0] C_BR    = 5'b11110;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_RESET = 5'b00110;

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .ex_halt(ex_halt), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_hold(pipe_hold), .halted(halted),
    .mem_error(mem_error), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_dest = 3'd0; ex_branch_taken = 1'b0; ex_halt = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_RESET); end
    checks++;
    if ({halted, mem_error} !== 2'b00 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_state got halted=%b err=%b stall=%0d exp 0 0 0", halted, mem_error, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = 0;
    #1;
    checks++;
    if (ctl !== C_NORM) begin errors++; $display("FAIL post_reset_ctl got %b exp %b", ctl, C_NORM); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    ex_mem_read = 1'b1; ex_dest = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rs_ctl got %b exp %b", ctl, C_LU); end
    exp_stall++;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (ctl !== C_NORM || stall_cycles !== 16'(exp_stall)) begin
      errors++; $display("FAIL load_use_release got ctl=%b stall=%0d exp ctl=%b stall=%0d", ctl, stall_cycles, C_NORM, exp_stall);
    end
    ex_mem_read = 1'b1; ex_dest = 3'd0; id_rs = 3'd0; id_uses_rs = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NORM) begin errors++; $display("FAIL load_use_r0 got %b exp %b", ctl, C_NORM); end
    ex_dest = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NORM) begin errors++; $display("FAIL load_use_unused_rs got %b exp %b", ctl, C_NORM); end
    id_rs = 3'd1; id_rt = 3'd3; id_uses_rt = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rt_ctl got %b exp %b", ctl, C_LU); end
    exp_stall++;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL load_use_count got %0d exp %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_branch_load_use();
    @(negedge clk);
    ex_mem_read = 1'b1; ex_dest = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BR) begin errors++; $display("FAIL branch_lu_ctl got %b exp %b", ctl, C_BR); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL branch_lu_count got %0d exp %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_mem_wait();
    @(negedge clk);
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_HOLD) begin errors++; $display("FAIL mem_wait_hold[%0d] got %b exp %b", i, ctl, C_HOLD); end
      @(negedge clk);
    end
    exp_stall += 3;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NORM) begin errors++; $display("FAIL mem_wait_release got %b exp %b", ctl, C_NORM); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cycles !== 16'(exp_stall) || halted !== 1'b0) begin
      errors++; $display("FAIL mem_wait_count got stall=%0d halted=%b exp %0d 0", stall_cycles, halted, exp_stall);
    end
  endtask

  task automatic test_branch_during_wait();
    @(negedge clk);
    mem_access = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_HOLD) begin errors++; $display("FAIL br_wait_hold[%0d] got %b exp %b", i, ctl, C_HOLD); end
      @(negedge clk);
    end
    exp_stall += 2;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BR) begin errors++; $display("FAIL br_wait_release got %b exp %b", ctl, C_BR); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL br_wait_count got %0d exp %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_halt();
    @(negedge clk);
    ex_halt = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NORM || halted !== 1'b0) begin errors++; $display("FAIL halt_entry_cycle got ctl=%b halted=%b exp %b 0", ctl, halted, C_NORM); end
    @(negedge clk);
    idle();
    ex_mem_read = 1'b1; ex_dest = 3'd2; id_rs = 3'd2; id_uses_rs = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b1 || mem_error !== 1'b0 || ctl !== C_HOLD) begin
      errors++; $display("FAIL halt_state got halted=%b err=%b ctl=%b exp 1 0 %b", halted, mem_error, ctl, C_HOLD);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall_cycles !== 16'(exp_stall) || halted !== 1'b1) begin
      errors++; $display("FAIL halt_frozen got stall=%0d halted=%b exp %0d 1", stall_cycles, halted, exp_stall);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ctl !== C_HOLD || halted !== 1'b0) begin
        errors++; $display("FAIL timeout_wait[%0d] got ctl=%b halted=%b exp %b 0", i, ctl, halted, C_HOLD);
      end
      @(negedge clk);
    end
    exp_stall += 5;
    #1;
    checks++;
    if (halted !== 1'b1 || mem_error !== 1'b1) begin errors++; $display("FAIL timeout_halt got halted=%b err=%b exp 1 1", halted, mem_error); end
    mem_access = 1'b0; ex_branch_taken = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ctl !== C_HOLD || stall_cycles !== 16'(exp_stall) || mem_error !== 1'b1) begin
      errors++; $display("FAIL timeout_frozen got ctl=%b stall=%0d err=%b exp %b %0d 1", ctl, stall_cycles, mem_error, C_HOLD, exp_stall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || mem_error !== 1'b0 || ctl !== C_RESET || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL timeout_async_reset got halted=%b err=%b ctl=%b stall=%0d exp 0 0 %b 0", halted, mem_error, ctl, stall_cycles, C_RESET);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    exp_stall = 0;
    #1;
    checks++;
    if (ctl !== C_NORM) begin errors++; $display("FAIL timeout_recover got %b exp %b", ctl, C_NORM); end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_dest = 3'd7; id_rs = 3'd7; id_uses_rs = 1'b1;
    repeat (65534) @(negedge clk);
    #1;
    checks++;
    if (stall_cycles !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h exp fffe", stall_cycles); end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (stall_cycles !== 16'hFFFF || ctl !== C_LU) begin
      errors++; $display("FAIL sat_hold got stall=%h ctl=%b exp ffff %b", stall_cycles, ctl, C_LU);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 0;
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_branch_during_wait();
    test_halt();
    test_timeout();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
